// File: rtl/uart_pkg.sv
// Shared UART receiver types and defaults: FSM state encoding, default clock/baud
// constants and the bit-timer counter width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StDone
    } rx_state_e;

    localparam int unsigned DefaultClkFrequency = 100_000_000;
    localparam int unsigned DefaultBaudRate     = 19_200;

    // Width of a counter that must hold 0..bit_cycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned bit_cycles);
        return (bit_cycles > 2) ? $clog2(bit_cycles) : 1;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the UART receiver: free-runs 0..BIT_CYCLES-1, restarts on clear,
// and pulses sample at the half-bit (half_sel) or full-bit terminal count.
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DefaultClkFrequency / DefaultBaudRate
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic half_sel,
    output logic sample
);

    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CntW        = cnt_width(BIT_CYCLES);

    localparam logic [CntW-1:0] FullTerm = CntW'(BIT_CYCLES - 1);
    localparam logic [CntW-1:0] HalfTerm = CntW'(HALF_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || count_q == FullTerm) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sample = (count_q == (half_sel ? HalfTerm : FullTerm));

endmodule

// File: rtl/rx.sv
// UART receiver: 8 data bits LSB first, optional odd parity (define RX_PARITY_EN), one stop
// bit, mid-bit sampling, level-held Receive with ReceiveAck handshake and error flags.
module rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = DefaultClkFrequency,
    parameter int unsigned BAUD_RATE     = DefaultBaudRate
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Sin,
    input  logic       ReceiveAck,
    output logic [7:0] Dout,
    output logic       Receive,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Overrun
);

    localparam int unsigned BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;

    rx_state_e  state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_q, stop_d;
    logic       sin_meta_q, sin_s;
    logic       sample, timer_clear, parity_err;

    logic [7:0] dout_q, dout_d;
    logic       recv_q, recv_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    // Synchronizer resets high so the idle line never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_meta_q <= 1'b1;
            sin_s      <= 1'b1;
        end else begin
            sin_meta_q <= Sin;
            sin_s      <= sin_meta_q;
        end
    end

    rx_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .half_sel(state_q == StStart),
        .sample  (sample)
    );

`ifdef RX_PARITY_EN
    logic par_q, par_d;
    assign parity_err = ~(^shreg_q ^ par_q);
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
`ifdef RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!sin_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (sample) begin
                    state_d = sin_s ? StIdle : StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (sample) begin
                    shreg_d = {sin_s, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            StPar: begin
                if (sample) begin
                    par_d   = sin_s;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (sample) begin
                    stop_d  = sin_s;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Timer restarts on every state entry; staying in DATA relies on its natural wrap.
    assign timer_clear = (state_d != state_q);

    // Frame completion takes priority over an acknowledge in the same cycle.
    always_comb begin
        dout_d = dout_q;
        recv_d = recv_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;
        if (state_q == StDone) begin
            dout_d = shreg_q;
            ferr_d = ~stop_q;
            perr_d = parity_err;
            ovr_d  = recv_q;
            recv_d = 1'b1;
        end else if (ReceiveAck && recv_q) begin
            recv_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b1;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
`endif
            dout_q  <= '0;
            recv_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
`endif
            dout_q  <= dout_d;
            recv_q  <= recv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Dout      = dout_q;
    assign Receive   = recv_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_rx.sv
// Scoreboard bench for rx: frames are serialised bit by bit, expected results queued at
// issue time, and a forked monitor checks each byte the receiver presents.
module tb_rx;

    localparam int unsigned BitCycles = 10;
`ifdef RX_PARITY_EN
    localparam int FrameBits = 11;
    localparam bit ParityOn  = 1'b1;
`else
    localparam int FrameBits = 10;
    localparam bit ParityOn  = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Sin = 1'b1;
    logic       ReceiveAck = 1'b0;
    logic [7:0] Dout;
    logic       Receive, ParityErr, FrameErr, Overrun;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   held = 1'b0;

    rx #(
        .CLK_FREQUENCY(1000),
        .BAUD_RATE    (100)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Sin       (Sin),
        .ReceiveAck(ReceiveAck),
        .Dout      (Dout),
        .Receive   (Receive),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Overrun   (Overrun)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    task automatic monitor();
        logic rcv_prev = 1'b0;
        logic ovr_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && ((Receive && !rcv_prev) || (Overrun && !ovr_prev))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got Dout=%0h with no frame pending", Dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", Dout, e.d);
                    check("parity_err", ParityErr, e.perr);
                    check("frame_err", FrameErr, e.ferr);
                    check("overrun", Overrun, e.ovr);
                end
            end
            rcv_prev = Receive;
            ovr_prev = Overrun;
        end
    endtask

    // abort_bit >= 0: reset the receiver mid-way through that frame bit and drop the frame.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int abort_bit);
        logic [10:0] fb;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = d;
        if (ParityOn) begin
            fb[9]  = par;
            fb[10] = stop;
        end else begin
            fb[9] = stop;
        end
        if (abort_bit < 0) begin
            exp_q.push_back('{d: d,
                              perr: ParityOn ? ~((^d) ^ par) : 1'b0,
                              ferr: ~stop,
                              ovr: held});
            held = 1'b1;
        end
        for (int b = 0; b < FrameBits; b++) begin
            Sin = fb[b];
            if (b == abort_bit) begin
                repeat (5) @(negedge clk);
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_dout", Dout, 0);
                check("rst_receive", Receive, 0);
                check("rst_overrun", Overrun, 0);
                check("rst_errs", {ParityErr, FrameErr}, 0);
                held = 1'b0;
                Sin = 1'b1;
                reset_n = 1'b1;
                repeat (20) @(negedge clk);
                return;
            end
            repeat (BitCycles) @(negedge clk);
        end
        Sin = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("frame_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat (15) @(negedge clk);
    endtask

    task automatic ack(input int hold);
        repeat (hold) @(negedge clk);
        check("receive_held", Receive, 1);
        ReceiveAck = 1'b1;
        @(negedge clk);
        ReceiveAck = 1'b0;
        check("receive_clr", Receive, 0);
        check("overrun_clr", Overrun, 0);
        held = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic par, stop;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_dout", Dout, 0);
        check("reset_receive", Receive, 0);
        check("reset_flags", {ParityErr, FrameErr, Overrun}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Stray acknowledge with nothing held is ignored.
        ReceiveAck = 1'b1;
        @(negedge clk);
        ReceiveAck = 1'b0;
        check("stray_ack", Receive, 0);

        send_frame(8'hA5, 1'b1, 1'b1, -1);
        ack(7);
        send_frame(8'h00, 1'b0, 1'b1, -1);
        ack(1);
        send_frame(8'h3C, ~(^8'h3C), 1'b0, -1);
        ack(2);

        // Short low glitch must not produce a byte.
        Sin = 1'b0;
        repeat (3) @(negedge clk);
        Sin = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_receive", Receive, 0);
        send_frame(8'h55, ~(^8'h55), 1'b1, -1);
        ack(1);

        send_frame(8'h11, ~(^8'h11), 1'b1, -1);
        send_frame(8'h22, ~(^8'h22), 1'b1, -1);
        ack(3);

        send_frame(8'h81, ~(^8'h81), 1'b1, -1);
        send_frame(8'h9E, ~(^8'h9E), 1'b1, 5);
        send_frame(8'hF0, ~(^8'hF0), 1'b1, -1);
        ack(1);

        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            par  = ($urandom_range(0, 4) == 0) ? (^d) : ~(^d);
            stop = ($urandom_range(0, 6) != 0);
            send_frame(d, par, stop, -1);
            // Leave some bytes unacknowledged to provoke overruns, never two in a row.
            if (Overrun || $urandom_range(0, 3) != 0) begin
                ack($urandom_range(1, 6));
            end
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        if (held) ack(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx.md
Name: rx

Overview:
- UART receiver that consumes the serial stream produced by the team's UART transmitter (its tx_out pin, looped back or from the host).
- Recovers one frame per character (start, 8 data LSB first, optional odd parity, stop) using a mid-bit sampling timer.
- Presents the byte with a level-held valid and acknowledge handshake, plus error flags, to a downstream consumer such as the seven-segment display or a buffer.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock rate in Hz.
- BAUD_RATE, 19_200: serial bit rate. BIT_CYCLES = CLK_FREQUENCY/BAUD_RATE (integer divide). HALF_CYCLES = BIT_CYCLES/2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- Sin  input  1  asynchronous serial line; idle high.
- ReceiveAck  input  1  consumer acknowledges the held byte.
- Dout  output  8  last received byte.
- Receive  output  1  byte valid; held high until acknowledged.
- ParityErr  output  1  parity error flag for the byte in Dout.
- FrameErr  output  1  stop bit was sampled as 0.
- Overrun  output  1  a new byte completed while Receive was still high.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - Dout=0, Receive=0, ParityErr=0, FrameErr=0, Overrun=0.
  - State IDLE, counters 0.
  - Both synchronizer flops reset to 1, so no false start bit after reset.
- Input synchronizer: two flops on Sin. All decisions use the second flop (sin_s).
- Bit timer: counts 0..BIT_CYCLES-1 and is cleared on every state entry. A "sample" fires when the count reaches its terminal value:
  - HALF_CYCLES-1 in START.
  - BIT_CYCLES-1 in every other timed state.
- States:
  - IDLE: when sin_s=0, go to START and clear the timer.
  - START: at the half-bit sample:
    - sin_s=0: go to DATA with bit index 0.
    - sin_s=1: glitch; return to IDLE with no output change.
  - DATA: at each full-bit sample, shift sin_s into shreg[7] (right shift, LSB first) and increment the index. After index 7, go to PAR if RX_PARITY_EN is defined, otherwise STOP.
  - PAR: at the sample, store the parity bit.
  - STOP: at the sample, go to DONE.
  - DONE: lasts one cycle. Then back to IDLE.
- Actions in DONE:
  - Dout <= shreg.
  - FrameErr <= ~sin_s (the stop-bit sample).
  - ParityErr <= parity result, or 0 when parity is compiled out.
  - Overrun <= Receive.
  - Receive <= 1.
- Handshake:
  - Receive stays high until ReceiveAck=1 is seen on a rising edge. It clears the next cycle.
  - ReceiveAck with Receive=0 is ignored.
  - ReceiveAck in the same cycle as DONE: DONE wins. Receive stays 1, and Overrun is set only if Receive was 1 before that cycle.
  - Overrun clears together with Receive on ack.
  - On overrun, Dout is overwritten with the newer byte.
- Error flags change only in DONE. FrameErr and ParityErr remain valid while Receive is high.
- Timing:
  - Data sample points fall at 2 + HALF_CYCLES + k*BIT_CYCLES cycles after the Sin falling edge (±1 cycle), k = 1..8.
  - Receive rises 1 cycle after the stop sample.
- A stop bit of 0 still completes the frame with FrameErr=1. The next IDLE then waits for sin_s=0: a break (Sin held low) immediately restarts START.
- reset_n deassertion mid-frame: the receiver returns to IDLE and the partial byte is discarded.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Frame is 11 bits with odd parity, matching the team's transmitter.
  - ParityErr = (^shreg ^ parity_bit) == 0, i.e. the XOR of the 8 data bits and the parity bit must be 1.
- Undefined:
  - Frame is 10 bits (8N1) and the PAR state is absent.
  - ParityErr is tied to 0.

Decomposition:
- uart_pkg holds:
  - The state enum typedef (IDLE, START, DATA, PAR, STOP, DONE).
  - Default CLK_FREQUENCY and BAUD_RATE constants.
  - A function computing the counter width, $clog2(BIT_CYCLES).
- One sub-module, rx_bit_timer: inputs clear and half_sel, output sample pulse, with parameter BIT_CYCLES.

Test Plan (bench uses CLK_FREQUENCY=1000, BAUD_RATE=100, so BIT_CYCLES=10; parity enabled unless stated):
- Send 0xA5 with correct odd parity (parity bit 1) and stop 1 -> Dout=0xA5, Receive=1, all errors 0. Receive holds until ReceiveAck, then clears 1 cycle later.
- Send 0x00 with parity bit 0 -> ParityErr=1, Dout=0x00. With RX_PARITY_EN undefined, send 0x00 in 8N1 -> ParityErr=0.
- Send 0x3C with stop bit 0 -> FrameErr=1, Dout=0x3C, Receive=1.
- Pulse Sin low for 3 cycles, then high -> no Receive, state back to IDLE. A following 0x55 frame is received correctly.
- Send 0x11, leave it unacknowledged, then send 0x22 -> Dout=0x22, Overrun=1. ReceiveAck clears both Receive and Overrun.
- Assert reset_n=0 during bit 4 of a frame, release it, send 0xF0 -> all outputs 0 during reset, then Dout=0xF0 with no errors.
